// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads one i_IM word per cycle into a
// 2-entry in-order FIFO and hands words to decode over valid/ready.
// Redirects flush the FIFO and reload the PC; fetch halts past the end of i_IM.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W     = 32,
  parameter int unsigned          IMEM_DEPTH = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0
) (
  input  logic              CLK,
  input  logic              START,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc4,
  output logic              halted
);

  typedef enum logic {FETCH, HALT} state_t;

  // one extra bit so the limit and PC+4 compare without wrapping
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(IMEM_DEPTH) << 2;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              push, pop;
  logic [ADDR_W:0]   pc_ext, pc4_ext;
  logic [31:0]       instr_mem [2];
  logic [ADDR_W-1:0] pc_mem    [2];

  assign pc_ext  = {1'b0, pc_q};
  assign pc4_ext = pc_ext + (ADDR_W+1)'(4);
  assign pop     = (count_q != 2'd0) && out_ready;

  // next-state logic: redirect beats push/pop, otherwise fetch while room
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    push     = 1'b0;
    if (redirect) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      pc_d     = redirect_pc & ~ADDR_W'(3);
      state_d  = FETCH;
    end else begin
      if (state_q == FETCH) begin
        if (pc_ext >= LIMIT)
          state_d = HALT;
        else if ((count_q < 2'd2) || pop)
          push = 1'b1;
      end
      if (push) begin
        pc_d     = pc_q + ADDR_W'(4);
        wr_ptr_d = ~wr_ptr_q;
        if (pc4_ext >= LIMIT)
          state_d = HALT;
      end
      if (pop)
        rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // control state register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!START) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // FIFO payload storage; entries are only visible while counted valid
  always_ff @(posedge CLK) begin
    if (START && push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= pc_q;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q] : '0;
  assign out_pc4   = out_valid ? (pc_mem[rd_ptr_q] + ADDR_W'(4)) : '0;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (32-word and 4-word i_IM) share
// stimulus; a queue-level model predicts every cycle, directed literals pin it.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        start, redirect, ready;
  logic [31:0] rpc;

  logic [31:0] addr_a, rdata_a, instr_a, pc_a, pc4_a;
  logic        valid_a, halt_a;
  logic [31:0] addr_b, rdata_b, instr_b, pc_b, pc4_b;
  logic        valid_b, halt_b;

  logic [31:0] im [32];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) im[i] = 32'h1000_0000 + i * 32'h111;

  assign rdata_a = im[addr_a[6:2]];
  assign rdata_b = im[addr_b[6:2]];

  instr_fetch_unit dut_a (
    .CLK(clk), .START(start), .imem_addr(addr_a), .imem_rdata(rdata_a),
    .redirect(redirect), .redirect_pc(rpc), .out_valid(valid_a),
    .out_ready(ready), .out_instr(instr_a), .out_pc(pc_a), .out_pc4(pc4_a),
    .halted(halt_a));

  instr_fetch_unit #(.IMEM_DEPTH(4)) dut_b (
    .CLK(clk), .START(start), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .redirect(redirect), .redirect_pc(rpc), .out_valid(valid_b),
    .out_ready(ready), .out_instr(instr_b), .out_pc(pc_b), .out_pc4(pc4_b),
    .halted(halt_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned lim [2] = '{128, 16};
  logic [31:0] m_pc  [2];
  int          m_cnt [2];
  logic        m_halt[2];
  logic [31:0] m_qi  [2][2];
  logic [31:0] m_qp  [2][2];
  logic        model_ok = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!start) begin
        m_pc[k] = 32'h0; m_cnt[k] = 0; m_halt[k] = 1'b0;
      end else if (redirect) begin
        m_cnt[k] = 0; m_halt[k] = 1'b0; m_pc[k] = {rpc[31:2], 2'b00};
      end else begin
        bit took, fetch;
        took  = (m_cnt[k] > 0) && ready;
        fetch = !m_halt[k] && (m_pc[k] < lim[k]) && (m_cnt[k] < 2 || took);
        if (!m_halt[k] && m_pc[k] >= lim[k]) m_halt[k] = 1'b1;
        if (took) begin
          m_qi[k][0] = m_qi[k][1]; m_qp[k][0] = m_qp[k][1]; m_cnt[k]--;
        end
        if (fetch) begin
          m_qi[k][m_cnt[k]] = im[m_pc[k][6:2]];
          m_qp[k][m_cnt[k]] = m_pc[k];
          m_cnt[k]++;
          m_pc[k] = m_pc[k] + 4;
          if (m_pc[k] >= lim[k]) m_halt[k] = 1'b1;
        end
      end
    end
    if (!start) model_ok = 1'b1;
  end

  task automatic cmp_dut(input int k, input logic v, input logic [31:0] ins,
                         input logic [31:0] p, input logic [31:0] p4,
                         input logic h, input logic [31:0] a);
    bit mv;
    mv = m_cnt[k] != 0;
    chk($sformatf("m%0d.valid", k), {31'b0, v}, {31'b0, mv});
    chk($sformatf("m%0d.instr", k), ins, mv ? m_qi[k][0] : 32'h0);
    chk($sformatf("m%0d.pc", k),    p,   mv ? m_qp[k][0] : 32'h0);
    chk($sformatf("m%0d.pc4", k),   p4,  mv ? m_qp[k][0] + 32'd4 : 32'h0);
    chk($sformatf("m%0d.halted", k), {31'b0, h}, {31'b0, m_halt[k]});
    chk($sformatf("m%0d.addr", k),  a,   m_pc[k]);
  endtask

  // compare process: every cycle, 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      cmp_dut(0, valid_a, instr_a, pc_a, pc4_a, halt_a, addr_a);
      cmp_dut(1, valid_b, instr_b, pc_b, pc4_b, halt_b, addr_b);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    start = 1'b0; cyc(1); start = 1'b1;
  endtask

  initial begin
    start = 1'b0; redirect = 1'b0; rpc = '0; ready = 1'b1;

    // 1: reset then in-order delivery at one word per cycle
    cyc(2);
    chk("rst.valid", {31'b0, valid_a}, 32'd0);
    chk("rst.instr", instr_a, 32'h0);
    chk("rst.pc",    pc_a,    32'h0);
    chk("rst.pc4",   pc4_a,   32'h0);
    chk("rst.halt",  {31'b0, halt_a}, 32'd0);
    start = 1'b1;
    cyc(1);
    chk("t1.valid", {31'b0, valid_a}, 32'd1);
    chk("t1.pc0",   pc_a,    32'h0);
    chk("t1.A",     instr_a, 32'h1000_0000);
    chk("t1.pc4",   pc4_a,   32'h4);
    cyc(1);
    chk("t1.pc1", pc_a, 32'h4); chk("t1.B", instr_a, 32'h1000_0111);
    cyc(1);
    chk("t1.pc2", pc_a, 32'h8); chk("t1.C", instr_a, 32'h1000_0222);

    // 2: stall fills FIFO, PC frozen, then lossless release
    do_reset(); ready = 1'b0;
    cyc(3);
    chk("t2.headA", instr_a, 32'h1000_0000);
    chk("t2.frozen", addr_a, 32'h8);
    ready = 1'b1;
    cyc(1);
    chk("t2.B", instr_a, 32'h1000_0111); chk("t2.pcB", pc_a, 32'h4);
    cyc(1);
    chk("t2.C", instr_a, 32'h1000_0222); chk("t2.pcC", pc_a, 32'h8);
    cyc(1);
    chk("t2.D", instr_a, 32'h1000_0333); chk("t2.pcD", pc_a, 32'hC);

    // 3: redirect while full flushes stale words, low bits dropped
    do_reset(); ready = 1'b0;
    cyc(3);
    redirect = 1'b1; rpc = 32'h13;
    cyc(1);
    redirect = 1'b0;
    chk("t3.flush", {31'b0, valid_a}, 32'd0);
    chk("t3.addr",  addr_a, 32'h10);
    ready = 1'b1;
    cyc(1);
    chk("t3.valid", {31'b0, valid_a}, 32'd1);
    chk("t3.pc",    pc_a,    32'h10);
    chk("t3.instr", instr_a, 32'h1000_0444);
    chk("t3.pc4",   pc4_a,   32'h14);

    // 4: 4-word memory halts after last push; redirect restarts
    do_reset(); ready = 1'b1;
    cyc(3);
    chk("t4.pc8",   pc_b, 32'h8);
    chk("t4.nohalt", {31'b0, halt_b}, 32'd0);
    cyc(1);
    chk("t4.pc12",  pc_b, 32'hC);
    chk("t4.halt",  {31'b0, halt_b}, 32'd1);
    cyc(1);
    chk("t4.drain", {31'b0, valid_b}, 32'd0);
    chk("t4.stay",  {31'b0, halt_b}, 32'd1);
    redirect = 1'b1; rpc = 32'h0;
    cyc(1);
    redirect = 1'b0;
    chk("t4.restart", {31'b0, halt_b}, 32'd0);
    cyc(1);
    chk("t4.re.valid", {31'b0, valid_b}, 32'd1);
    chk("t4.re.pc", pc_b, 32'h0);
    redirect = 1'b1; rpc = 32'h40;
    cyc(1);
    redirect = 1'b0;
    chk("t4.oor0", {31'b0, halt_b}, 32'd0);
    cyc(1);
    chk("t4.oor1", {31'b0, halt_b}, 32'd1);
    chk("t4.oorv", {31'b0, valid_b}, 32'd0);

    // 5: redirect beats pop on a full FIFO; reset beats redirect
    do_reset(); ready = 1'b0;
    cyc(3);
    ready = 1'b1; redirect = 1'b1; rpc = 32'h24;
    cyc(1);
    chk("t5.flush", {31'b0, valid_a}, 32'd0);
    chk("t5.addr",  addr_a, 32'h24);
    start = 1'b0; rpc = 32'h30;
    cyc(1);
    chk("t5.rstpc", addr_a, 32'h0);
    chk("t5.rstv",  {31'b0, valid_a}, 32'd0);
    start = 1'b1; redirect = 1'b0;
    cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
